// File: rtl/inv_arbiter.sv
// rtl/inv_arbiter.sv - round-robin sequencer sharing one modular-inverse unit among NREQ clients
module inv_arbiter #(
    parameter int N       = 256,
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 2048
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*N-1:0]   req_p,
    input  logic [NREQ*N-1:0]   req_a,
    output logic [NREQ-1:0]     done,
    output logic [N-1:0]        result,
    output logic                err,
    output logic                busy,
    output logic                inv_enable,
    output logic                inv_reset,
    output logic [N-1:0]        inv_p,
    output logic [N-1:0]        inv_a,
    input  logic [N-1:0]        inv_x,
    input  logic                inv_ready
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_CLIENT = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [IW-1:0]      r_rr_ptr;
    logic [IW-1:0]      r_grant;
    logic [NREQ-1:0]    r_done;
    logic [N-1:0]       r_result;
    logic               r_err;
    logic               r_busy;
    logic               r_inv_enable;
    logic               r_inv_reset;
    logic [N-1:0]       r_inv_p;
    logic [N-1:0]       r_inv_a;
    logic [TW-1:0]      r_timer;

    state_t             w_state;
    logic [IW-1:0]      w_rr_ptr;
    logic [IW-1:0]      w_grant;
    logic [NREQ-1:0]    w_done;
    logic [N-1:0]       w_result;
    logic               w_err;
    logic               w_inv_enable;
    logic               w_inv_reset;
    logic [N-1:0]       w_inv_p;
    logic [N-1:0]       w_inv_a;
    logic [TW-1:0]      w_timer;

    logic               w_found;
    logic [IW-1:0]      w_win;
    logic [N-1:0]       w_sel_p;
    logic [N-1:0]       w_sel_a;

    // Round-robin search: first requester at or after the pointer, wrapping modulo NREQ
    always_comb begin
        int            sum;
        logic [IW-1:0] cand;
        w_found = 1'b0;
        w_win   = '0;
        sum     = 0;
        cand    = '0;
        for (int off = 0; off < NREQ; off++) begin
            sum = int'(r_rr_ptr) + off;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            cand = IW'(sum);
            if (!w_found && req[cand]) begin
                w_found = 1'b1;
                w_win   = cand;
            end
        end
    end

    assign w_sel_p = req_p[w_win*N +: N];
    assign w_sel_a = req_a[w_win*N +: N];

    // Next-state and next-register values; every output leaves through a register
    always_comb begin
        w_state      = r_state;
        w_rr_ptr     = r_rr_ptr;
        w_grant      = r_grant;
        w_done       = '0;
        w_result     = r_result;
        w_err        = r_err;
        w_inv_enable = 1'b0;
        w_inv_reset  = 1'b0;
        w_inv_p      = r_inv_p;
        w_inv_a      = r_inv_a;
        w_timer      = r_timer;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant = w_win;
                    w_inv_p = w_sel_p;
                    w_inv_a = w_sel_a;
                    if (w_sel_a == '0) begin
                        // zero has no inverse: answer at once, unit is never started
                        w_state       = S_DONE;
                        w_done[w_win] = 1'b1;
                        w_result      = '0;
                        w_err         = 1'b1;
                    end else begin
                        w_state      = S_ISSUE;
                        w_inv_enable = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                w_timer = '0;
                w_state = S_WAIT;
            end
            S_WAIT: begin
                if (inv_ready) begin
                    // a completion on the last watchdog cycle still counts as success
                    w_result        = inv_x;
                    w_err           = 1'b0;
                    w_done[r_grant] = 1'b1;
                    w_state         = S_DONE;
                end else if (r_timer == TIMER_LAST) begin
                    w_inv_reset     = 1'b1;
                    w_result        = '0;
                    w_err           = 1'b1;
                    w_done[r_grant] = 1'b1;
                    w_state         = S_DONE;
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            S_DONE: begin
                w_rr_ptr = (r_grant == LAST_CLIENT) ? '0 : r_grant + IW'(1);
                w_state  = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Datapath and output registers; reset abandons any job in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_done       <= '0;
            r_result     <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_inv_enable <= 1'b0;
            r_inv_reset  <= 1'b0;
            r_inv_p      <= '0;
            r_inv_a      <= '0;
            r_timer      <= '0;
        end else begin
            r_rr_ptr     <= w_rr_ptr;
            r_grant      <= w_grant;
            r_done       <= w_done;
            r_result     <= w_result;
            r_err        <= w_err;
            r_busy       <= (w_state != S_IDLE);
            r_inv_enable <= w_inv_enable;
            r_inv_reset  <= w_inv_reset;
            r_inv_p      <= w_inv_p;
            r_inv_a      <= w_inv_a;
            r_timer      <= w_timer;
        end
    end

    assign done       = r_done;
    assign result     = r_result;
    assign err        = r_err;
    assign busy       = r_busy;
    assign inv_enable = r_inv_enable;
    assign inv_reset  = r_inv_reset;
    assign inv_p      = r_inv_p;
    assign inv_a      = r_inv_a;

endmodule

// File: tb/tb_inv_arbiter.sv
// tb/tb_inv_arbiter.sv - scoreboard bench for inv_arbiter with a stub inverse unit
module tb_inv_arbiter;

    localparam int N       = 16;
    localparam int NREQ    = 3;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*N-1:0]   req_p = '0;
    logic [NREQ*N-1:0]   req_a = '0;
    logic [NREQ-1:0]     done;
    logic [N-1:0]        result;
    logic                err;
    logic                busy;
    logic                inv_enable;
    logic                inv_reset;
    logic [N-1:0]        inv_p;
    logic [N-1:0]        inv_a;
    logic [N-1:0]        inv_x = '0;
    logic                inv_ready = 1'b0;

    inv_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_p      (req_p),
        .req_a      (req_a),
        .done       (done),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .inv_enable (inv_enable),
        .inv_reset  (inv_reset),
        .inv_p      (inv_p),
        .inv_a      (inv_a),
        .inv_x      (inv_x),
        .inv_ready  (inv_ready)
    );

    always #5 clk = ~clk;

    // kind: 0 = a==0, 1 = normal completion, 2 = watchdog abort
    typedef struct {
        int client;
        int res;
        int err;
        int kind;
        int p;
        int a;
    } exp_t;

    exp_t   exp_q[$];
    int     rd_idx = 0;
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    int     rst_id = 0;
    int     idle_id = 0;
    int     tmo_id = 0;

    bit     stub_hang = 1'b0;
    int     en_count = 0;
    longint en_cycle = 0;
    longint ready_cycle = 0;
    int     cap_p = 0;
    int     cap_a = 0;

    int     m_ptr = 0;
    int     cl_cnt[NREQ];
    int     b_cnt[NREQ];
    int     b_p[NREQ];
    int     b_a[NREQ];

    function automatic int minv(input int a, input int p);
        for (int x = 1; x < p; x++) begin
            if ((a * x) % p == 1) return x;
        end
        return 0;
    endfunction

    function automatic int powmod(input int b, input int e, input int m);
        longint r, bb;
        int     ee;
        r = 1;
        bb = b % m;
        ee = e;
        while (ee > 0) begin
            if (ee[0]) r = (r * bb) % m;
            bb = (bb * bb) % m;
            ee = ee >> 1;
        end
        return int'(r);
    endfunction

    task automatic check(input string name, input longint got, input longint expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Stub inverse unit: random latency, Fermat inverse, spurious ready pulses while idle
    initial begin : stub
        bit stub_active;
        int stub_cnt;
        stub_active = 1'b0;
        stub_cnt = 0;
        forever begin
            @(negedge clk);
            inv_ready = 1'b0;
            if (reset) begin
                stub_active = 1'b0;
            end else begin
                if (inv_reset) stub_active = 1'b0;
                if (stub_active) begin
                    stub_cnt--;
                    if (stub_cnt == 0) begin
                        inv_ready = 1'b1;
                        inv_x = N'(powmod(cap_a, cap_p - 2, cap_p));
                        stub_active = 1'b0;
                        ready_cycle = cyc;
                    end
                end else if (inv_enable) begin
                    en_count++;
                    en_cycle = cyc;
                    cap_p = int'(inv_p);
                    cap_a = int'(inv_a);
                    stub_cnt = $urandom_range(1, 6);
                    stub_active = !stub_hang;
                end else if (!busy && $urandom_range(0, 3) == 0) begin
                    inv_ready = 1'b1;
                    inv_x = N'($urandom);
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every done and services check requests
    initial begin : monitor
        exp_t e;
        int   en_seen;
        int   prev_busy;
        int   rst_seen;
        int   idle_seen;
        int   tmo_seen;
        en_seen = 0;
        prev_busy = 0;
        rst_seen = 0;
        idle_seen = 0;
        tmo_seen = 0;
        forever begin
            @(negedge clk);
            if (rst_id != rst_seen) begin
                rst_seen = rst_id;
                check("rst_done", done, 0);
                check("rst_result", result, 0);
                check("rst_err", err, 0);
                check("rst_busy", busy, 0);
                check("rst_inv_enable", inv_enable, 0);
                check("rst_inv_reset", inv_reset, 0);
                check("rst_inv_p", inv_p, 0);
                check("rst_inv_a", inv_a, 0);
            end
            if (tmo_id != tmo_seen) begin
                tmo_seen = tmo_id;
                check("wait_bound", 1, 0);
            end
            if (idle_id != idle_seen) begin
                idle_seen = idle_id;
                check("busy_idle", busy, 0);
                check("queue_drained", exp_q.size() - rd_idx, 0);
            end
            if (reset) begin
                en_seen = en_count;
            end else if (|done) begin
                check("done_expected", (rd_idx < exp_q.size()) ? 1 : 0, 1);
                if (rd_idx < exp_q.size()) begin
                    e = exp_q[rd_idx];
                    rd_idx++;
                    check("done_onehot", done, 1 << e.client);
                    check("result", result, e.res);
                    check("err", err, e.err);
                    check("busy_done", busy, 1);
                    check("enable_count", en_count - en_seen, (e.kind == 0) ? 0 : 1);
                    check("inv_reset", inv_reset, (e.kind == 2) ? 1 : 0);
                    check("inv_p", inv_p, e.p);
                    check("inv_a", inv_a, e.a);
                    if (e.kind == 0) begin
                        check("zero_latency", prev_busy, 0);
                    end else begin
                        check("issue_p", cap_p, e.p);
                        check("issue_a", cap_a, e.a);
                        if (e.kind == 1) check("done_after_ready", cyc, ready_cycle + 1);
                        else             check("timeout_latency", cyc, en_cycle + TIMEOUT + 1);
                    end
                end
                en_seen = en_count;
            end
            prev_busy = busy;
        end
    end

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++) begin
            if (cl_cnt[i] > 0) return 1'b1;
        end
        return (rd_idx < exp_q.size());
    endfunction

    task automatic run_until_idle(input int maxc);
        int c;
        c = 0;
        while (pending() && c < maxc) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (done[i] && cl_cnt[i] > 0) begin
                    cl_cnt[i]--;
                    if (cl_cnt[i] == 0) req[i] = 1'b0;
                end
            end
            c++;
        end
        if (pending()) begin
            tmo_id++;
            for (int i = 0; i < NREQ; i++) cl_cnt[i] = 0;
            req = '0;
        end
        @(negedge clk);
        @(negedge clk);
        idle_id++;
        @(negedge clk);
    endtask

    // Each client with b_cnt>0 holds req for that many jobs; service order follows round robin
    task automatic issue_batch(input bit hang);
        int   left[NREQ];
        int   ptr;
        int   total;
        int   pick;
        exp_t e;
        @(negedge clk);
        stub_hang = hang;
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            left[i] = b_cnt[i];
            total += b_cnt[i];
        end
        ptr = m_ptr;
        for (int j = 0; j < total; j++) begin
            pick = -1;
            for (int off = 0; off < NREQ; off++) begin
                if (pick < 0 && left[(ptr + off) % NREQ] > 0) pick = (ptr + off) % NREQ;
            end
            e.client = pick;
            e.p = b_p[pick];
            e.a = b_a[pick];
            if (b_a[pick] == 0) begin
                e.kind = 0; e.res = 0; e.err = 1;
            end else if (hang) begin
                e.kind = 2; e.res = 0; e.err = 1;
            end else begin
                e.kind = 1; e.res = minv(b_a[pick], b_p[pick]); e.err = 0;
            end
            exp_q.push_back(e);
            left[pick]--;
            ptr = (pick + 1) % NREQ;
        end
        m_ptr = ptr;
        for (int i = 0; i < NREQ; i++) begin
            req_p[i*N +: N] = N'(b_p[i]);
            req_a[i*N +: N] = N'(b_a[i]);
            cl_cnt[i] = b_cnt[i];
            req[i] = (b_cnt[i] > 0);
        end
        run_until_idle(400);
    endtask

    task automatic set_client(input int i, input int cnt, input int p, input int a);
        b_cnt[i] = cnt;
        b_p[i] = p;
        b_a[i] = a;
    endtask

    task automatic clear_batch();
        for (int i = 0; i < NREQ; i++) set_client(i, 0, 7, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin : main
        int primes[8];
        int c;
        int p;
        primes = '{7, 11, 13, 23, 29, 101, 127, 251};
        for (int i = 0; i < NREQ; i++) cl_cnt[i] = 0;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        rst_id++;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        clear_batch(); set_client(0, 1, 23, 5); issue_batch(1'b0);
        clear_batch(); set_client(1, 1, 7, 3);  issue_batch(1'b0);
        clear_batch(); set_client(2, 1, 23, 0); issue_batch(1'b0);
        clear_batch(); set_client(0, 2, 23, 5); set_client(1, 1, 23, 5); set_client(2, 1, 23, 5);
        issue_batch(1'b0);
        clear_batch(); set_client(0, 1, 23, 5); issue_batch(1'b1);
        clear_batch(); set_client(2, 1, 23, 5); issue_batch(1'b0);

        // Reset in the middle of a hung job: no done may follow
        stub_hang = 1'b1;
        @(negedge clk);
        req_p[1*N +: N] = N'(7);
        req_a[1*N +: N] = N'(3);
        req[1] = 1'b1;
        c = 0;
        while (!inv_enable && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (!inv_enable) tmo_id++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        req = '0;
        @(negedge clk);
        rst_id++;
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
        repeat (8) @(negedge clk);
        clear_batch(); set_client(1, 1, 7, 3); issue_batch(1'b0);

        for (int n = 0; n < 30; n++) begin
            clear_batch();
            for (int i = 0; i < NREQ; i++) begin
                p = primes[$urandom_range(0, 7)];
                set_client(i, $urandom_range(0, 2), p,
                           ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, p - 1));
            end
            if (b_cnt[0] + b_cnt[1] + b_cnt[2] == 0) b_cnt[$urandom_range(0, 2)] = 1;
            issue_batch($urandom_range(0, 9) == 0);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
